// File: rtl/usb_reg_arb_if.sv
// Register-bus bundle joining two bus masters and one shared register slave to the arbiter.
interface usb_reg_arb_if #(
    parameter int AW = 11
);
    logic          m0_cs;
    logic          m0_wr;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata;
    logic [3:0]    m0_be;
    logic [31:0]   m0_rdata;
    logic          m0_ack;
    logic          m0_err;

    logic          m1_cs;
    logic          m1_wr;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata;
    logic [3:0]    m1_be;
    logic [31:0]   m1_rdata;
    logic          m1_ack;
    logic          m1_err;

    logic          s_cs;
    logic          s_wr;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_be;
    logic [31:0]   s_rdata;
    logic          s_ack;

    // master: the requesting environment (both bus masters plus the slave's reply); slave: the arbiter
    modport master (
        output m0_cs, m0_wr, m0_addr, m0_wdata, m0_be,
        input  m0_rdata, m0_ack, m0_err,
        output m1_cs, m1_wr, m1_addr, m1_wdata, m1_be,
        input  m1_rdata, m1_ack, m1_err,
        input  s_cs, s_wr, s_addr, s_wdata, s_be,
        output s_rdata, s_ack
    );

    modport slave (
        input  m0_cs, m0_wr, m0_addr, m0_wdata, m0_be,
        output m0_rdata, m0_ack, m0_err,
        input  m1_cs, m1_wr, m1_addr, m1_wdata, m1_be,
        output m1_rdata, m1_ack, m1_err,
        output s_cs, s_wr, s_addr, s_wdata, s_be,
        input  s_rdata, s_ack
    );
endinterface

// File: rtl/usb_reg_arb.sv
// Two-master round-robin arbiter in front of a single register slave, with a BUSY timeout
// that turns a missing slave ack into an error response.
module usb_reg_arb #(
    parameter int TIMEOUT_CYC = 255,
    parameter int AW          = 11
) (
    input  logic         app_clk,
    input  logic         reset_ssn,
    usb_reg_arb_if.slave bus,
    output logic         busy,
    output logic         grant_id
);
    localparam int CW        = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam int TO_LAST_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] to_cnt;

    logic          win_id;
    logic          win_wr;
    logic [AW-1:0] win_addr;
    logic [31:0]   win_wdata;
    logic [3:0]    win_be;
    logic          timeout_hit;
    logic [31:0]   rsp_data;

    // Round-robin pick: a lone requester wins, a tie goes to the master not granted last time
    always_comb begin
        win_id = 1'b0;
        if (bus.m0_cs && bus.m1_cs) begin
            win_id = ~last_grant;
        end else if (bus.m1_cs) begin
            win_id = 1'b1;
        end
        win_wr    = win_id ? bus.m1_wr    : bus.m0_wr;
        win_addr  = win_id ? bus.m1_addr  : bus.m0_addr;
        win_wdata = win_id ? bus.m1_wdata : bus.m0_wdata;
        win_be    = win_id ? bus.m1_be    : bus.m0_be;
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
    assign rsp_data    = bus.s_ack ? bus.s_rdata : 32'h0;

    always_ff @(posedge app_clk or negedge reset_ssn) begin
        if (!reset_ssn) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            busy         <= 1'b0;
            to_cnt       <= '0;
            bus.s_cs     <= 1'b0;
            bus.s_wr     <= 1'b0;
            bus.s_addr   <= '0;
            bus.s_wdata  <= '0;
            bus.s_be     <= '0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m1_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.m0_cs || bus.m1_cs) begin
                        state       <= BUSY;
                        busy        <= 1'b1;
                        grant_id    <= win_id;
                        last_grant  <= win_id;
                        to_cnt      <= '0;
                        bus.s_cs    <= 1'b1;
                        bus.s_wr    <= win_wr;
                        bus.s_addr  <= win_addr;
                        bus.s_wdata <= win_wdata;
                        bus.s_be    <= win_be;
                    end
                end
                BUSY: begin
                    if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    // An ack arriving in the timeout cycle still counts as a normal completion
                    if (bus.s_ack || timeout_hit) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        bus.s_cs <= 1'b0;
                        if (grant_id == 1'b0) begin
                            bus.m0_ack   <= bus.s_ack;
                            bus.m0_err   <= ~bus.s_ack;
                            bus.m0_rdata <= rsp_data;
                        end else begin
                            bus.m1_ack   <= bus.s_ack;
                            bus.m1_err   <= ~bus.s_ack;
                            bus.m1_rdata <= rsp_data;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.m0_ack   <= 1'b0;
                    bus.m0_err   <= 1'b0;
                    bus.m0_rdata <= '0;
                    bus.m1_ack   <= 1'b0;
                    bus.m1_err   <= 1'b0;
                    bus.m1_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_reg_arb.sv
// Scoreboard bench for usb_reg_arb: each accepted request queues its expected grant,
// slave-strobe length and master response; a negedge monitor pops and checks them.
module tb_usb_reg_arb;
    localparam int AW = 11;
    localparam int TO = 4;

    typedef struct {
        logic          mid;
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        int            slen;
        logic          err;
        logic [31:0]   rdata;
    } txn_t;

    logic app_clk;
    logic reset_ssn;
    logic busy;
    logic grant_id;

    usb_reg_arb_if #(.AW(AW)) bus ();

    usb_reg_arb #(.TIMEOUT_CYC(TO), .AW(AW)) dut (
        .app_clk  (app_clk),
        .reset_ssn(reset_ssn),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    int            total = 0;
    int            bad   = 0;
    txn_t          exp_q[$];
    int            slave_dly = 0;
    logic          stray_ack = 1'b0;
    logic          model_last = 1'b1;
    logic          drop_req[2];
    logic          d_wr[2];
    logic [AW-1:0] d_addr[2];
    logic [31:0]   d_wdata[2];
    logic [3:0]    d_be[2];

    initial begin
        app_clk = 1'b0;
        forever #5 app_clk = ~app_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] slaveData(input logic [AW-1:0] a);
        if (a == AW'(32'h040)) return 32'h1234_5678;
        return 32'h5A00_0000 ^ (32'(a) << 16) ^ 32'(a);
    endfunction

    task automatic applyStimulus(input logic mid, input logic wr, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        d_wr[mid] = wr;
        d_addr[mid] = addr;
        d_wdata[mid] = wdata;
        d_be[mid] = be;
        if (mid == 1'b0) begin
            bus.m0_wr = wr; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be; bus.m0_cs = 1'b1;
        end else begin
            bus.m1_wr = wr; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be; bus.m1_cs = 1'b1;
        end
    endtask

    task automatic expectTxn(input logic mid);
        txn_t t;
        t.mid   = mid;
        t.wr    = d_wr[mid];
        t.addr  = d_addr[mid];
        t.wdata = d_wdata[mid];
        t.be    = d_be[mid];
        t.err   = (slave_dly >= TO);
        t.slen  = t.err ? TO : slave_dly + 1;
        t.rdata = t.err ? 32'h0 : slaveData(d_addr[mid]);
        exp_q.push_back(t);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge app_clk);
            n++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge app_clk);
        checkOutput("no_regrant", 32'(bus.s_cs), 32'h0);
    endtask

    // Register slave model: acks after slave_dly BUSY cycles, never when slave_dly >= TO
    initial begin
        int   scnt;
        logic prev;
        scnt = 0;
        prev = 1'b0;
        bus.s_ack = 1'b0;
        bus.s_rdata = 32'h0;
        forever begin
            @(posedge app_clk);
            #1;
            if (bus.s_cs) begin
                scnt = prev ? scnt + 1 : 0;
                bus.s_ack = (scnt == slave_dly);
                bus.s_rdata = bus.s_ack ? slaveData(bus.s_addr) : 32'hDEAD_BEEF;
            end else begin
                scnt = 0;
                bus.s_ack = stray_ack;
                bus.s_rdata = 32'hBAD0_BAD0;
            end
            prev = bus.s_cs;
        end
    end

    initial begin
        drop_req[0] = 1'b0;
        drop_req[1] = 1'b0;
        forever begin
            @(posedge app_clk);
            #1;
            if (drop_req[0]) begin bus.m0_cs = 1'b0; drop_req[0] = 1'b0; end
            if (drop_req[1]) begin bus.m1_cs = 1'b0; drop_req[1] = 1'b0; end
        end
    end

    // Monitor: grant fields and strobe length against the queue head, responses pop the queue
    initial begin
        int   scs_cnt;
        logic prev_scs;
        logic a0, a1;
        txn_t e;
        scs_cnt = 0;
        prev_scs = 1'b0;
        forever begin
            @(negedge app_clk);
            if (!reset_ssn) begin
                scs_cnt = 0;
                prev_scs = 1'b0;
            end else begin
                if (bus.s_cs) begin
                    if (!prev_scs) begin
                        scs_cnt = 0;
                        if (exp_q.size() == 0) begin
                            checkOutput("unexp_grant", 32'h1, 32'h0);
                        end else begin
                            checkOutput("grant_id", 32'(grant_id), 32'(exp_q[0].mid));
                            checkOutput("busy", 32'(busy), 32'h1);
                        end
                    end
                    scs_cnt++;
                    if (exp_q.size() != 0) begin
                        checkOutput("s_wr", 32'(bus.s_wr), 32'(exp_q[0].wr));
                        checkOutput("s_addr", 32'(bus.s_addr), 32'(exp_q[0].addr));
                        checkOutput("s_wdata", bus.s_wdata, exp_q[0].wdata);
                        checkOutput("s_be", 32'(bus.s_be), 32'(exp_q[0].be));
                    end
                end else if (prev_scs && exp_q.size() != 0) begin
                    checkOutput("s_cs_len", 32'(scs_cnt), 32'(exp_q[0].slen));
                end
                a0 = bus.m0_ack | bus.m0_err;
                a1 = bus.m1_ack | bus.m1_err;
                if (a0 | a1) begin
                    checkOutput("one_rsp", 32'((a0 & a1) | (bus.m0_ack & bus.m0_err) | (bus.m1_ack & bus.m1_err)), 32'h0);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexp_rsp", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_mid", 32'(a1), 32'(e.mid));
                        if (e.mid == 1'b0) begin
                            checkOutput("m0_err", 32'(bus.m0_err), 32'(e.err));
                            checkOutput("m0_rdata", bus.m0_rdata, e.rdata);
                            checkOutput("m1_rdata_idle", bus.m1_rdata, 32'h0);
                        end else begin
                            checkOutput("m1_err", 32'(bus.m1_err), 32'(e.err));
                            checkOutput("m1_rdata", bus.m1_rdata, e.rdata);
                            checkOutput("m0_rdata_idle", bus.m0_rdata, 32'h0);
                        end
                    end
                    drop_req[a1] = 1'b1;
                end
                prev_scs = bus.s_cs;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic mid;
        logic ok;
        reset_ssn = 1'b1;
        bus.m0_cs = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
        bus.m1_cs = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
        #2 reset_ssn = 1'b0;
        repeat (3) @(negedge app_clk);
        checkOutput("rst_s_cs", 32'(bus.s_cs), 32'h0);
        checkOutput("rst_s_wr", 32'(bus.s_wr), 32'h0);
        checkOutput("rst_s_addr", 32'(bus.s_addr), 32'h0);
        checkOutput("rst_s_wdata", bus.s_wdata, 32'h0);
        checkOutput("rst_s_be", 32'(bus.s_be), 32'h0);
        checkOutput("rst_m0_rsp", {bus.m0_rdata[29:0], bus.m0_ack, bus.m0_err}, 32'h0);
        checkOutput("rst_m1_rsp", {bus.m1_rdata[29:0], bus.m1_ack, bus.m1_err}, 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
        @(posedge app_clk); #1 reset_ssn = 1'b1;

        // Simultaneous requests, twice: round-robin order from the model's last grant
        slave_dly = 0;
        for (int r = 0; r < 2; r++) begin
            @(posedge app_clk); #1;
            applyStimulus(1'b0, 1'b0, AW'(32'h100 + r), 32'h0, 4'hF);
            applyStimulus(1'b1, 1'b0, AW'(32'h200 + r), 32'h0, 4'hF);
            mid = ~model_last;
            expectTxn(mid);
            expectTxn(~mid);
            model_last = ~mid;
            waitDrain(40);
        end

        slave_dly = 1;
        @(posedge app_clk); #1;
        applyStimulus(1'b0, 1'b0, AW'(32'h040), 32'h0, 4'hF);
        expectTxn(1'b0); model_last = 1'b0;
        waitDrain(30);

        slave_dly = 2;
        @(posedge app_clk); #1;
        applyStimulus(1'b0, 1'b1, AW'(32'h123), 32'hA5A5_0001, 4'b0011);
        expectTxn(1'b0); model_last = 1'b0;
        waitDrain(30);

        slave_dly = 255;
        @(posedge app_clk); #1;
        applyStimulus(1'b1, 1'b0, AW'(32'h3F0), 32'h0, 4'hF);
        expectTxn(1'b1); model_last = 1'b1;
        waitDrain(30);

        slave_dly = TO - 1;
        @(posedge app_clk); #1;
        applyStimulus(1'b1, 1'b0, AW'(32'h011), 32'h0, 4'hF);
        expectTxn(1'b1); model_last = 1'b1;
        waitDrain(30);

        @(posedge app_clk); #1 stray_ack = 1'b1;
        repeat (3) @(posedge app_clk);
        #1 stray_ack = 1'b0;
        repeat (4) @(negedge app_clk);
        checkOutput("stray_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 6; i++) begin
            slave_dly = int'($urandom_range(0, 5));
            mid = 1'($urandom_range(0, 1));
            @(posedge app_clk); #1;
            applyStimulus(mid, 1'($urandom), AW'($urandom), $urandom, 4'($urandom));
            expectTxn(mid); model_last = mid;
            waitDrain(30);
        end

        // Reset pulsed in the second BUSY cycle: transfer aborted, no response afterwards
        slave_dly = 10;
        @(posedge app_clk); #1;
        applyStimulus(1'b1, 1'b0, AW'(32'h055), 32'h0, 4'hF);
        expectTxn(1'b1);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge app_clk); #1;
            ok = bus.s_cs;
        end
        checkOutput("abort_grant_seen", 32'(ok), 32'h1);
        @(posedge app_clk); #1 reset_ssn = 1'b0;
        #1;
        checkOutput("abort_s_cs", 32'(bus.s_cs), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_grant_id", 32'(grant_id), 32'h0);
        exp_q.delete();
        bus.m1_cs = 1'b0;
        model_last = 1'b1;
        repeat (2) @(posedge app_clk);
        #1 reset_ssn = 1'b1;
        repeat (6) @(negedge app_clk);
        checkOutput("abort_idle", 32'(bus.s_cs), 32'h0);

        slave_dly = 1;
        @(posedge app_clk); #1;
        applyStimulus(1'b0, 1'b0, AW'(32'h077), 32'h0, 4'hF);
        expectTxn(1'b0); model_last = 1'b0;
        waitDrain(30);

        checkOutput("q_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
